// File: rtl/i2c_xfer_seq.sv
// Register-level I2C transfer sequencer: turns write/read requests into APB
// accesses on an OpenCores-style I2C master (prescale, control, data, cmd/status).
module i2c_xfer_seq #(
  parameter int REG_PRERLO = 0,
  parameter int REG_PRERHI = 1,
  parameter int REG_CTR    = 2,
  parameter int REG_DR     = 3,
  parameter int REG_CMDSR  = 4,
  parameter int POLL_MAX   = 4095
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] cfg_prescale,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [6:0]  req_dev,
  input  logic [7:0]  req_reg,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [7:0]  m_paddr,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_SET_DR, S_SET_CMD, S_POLL, S_CHECK, S_STOP_ON_NACK, S_RD_DR, S_RESP
  } state_e;
  typedef enum logic [1:0] {AP_IDLE, AP_SETUP, AP_ACCESS} ap_e;

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [7:0] A_PRERLO = 8'(REG_PRERLO * 4);
  localparam logic [7:0] A_PRERHI = 8'(REG_PRERHI * 4);
  localparam logic [7:0] A_CTR    = 8'(REG_CTR * 4);
  localparam logic [7:0] A_DR     = 8'(REG_DR * 4);
  localparam logic [7:0] A_CMDSR  = 8'(REG_CMDSR * 4);

  state_e        state_q;
  ap_e           ap_q;
  logic [1:0]    idx_q, init_q;
  logic [PW-1:0] poll_q;
  logic          wr_q, stop_q, pend_q;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q, wdata_q;
  logic          sr_al_q, sr_tip_q, sr_rxack_q;
  logic          ready_q, valid_q, psel_q, penable_q, pwrite_q;
  logic [7:0]    rdata_q, paddr_q;
  logic [1:0]    err_q;
  logic [31:0]   pwdata_q;

  logic          launch;
  state_e        tgt_st;
  logic [1:0]    tgt_idx, tgt_init, last_idx;
  logic          cur_wr, x_write;
  logic [7:0]    x_addr, x_data;
  logic          unused_prdata;

  assign unused_prdata = ^m_prdata[31:8];
  assign last_idx = wr_q ? 2'd2 : 2'd3;
  // Only the fourth read byte (RD command) has no WR bit, so no RXACK to check.
  assign cur_wr = (idx_q != 2'd3);

  function automatic logic [7:0] byte_dat(input logic [1:0] i, input logic w,
                                          input logic [6:0] d, input logic [7:0] r,
                                          input logic [7:0] wd);
    case (i)
      2'd0:    byte_dat = {d, 1'b0};
      2'd1:    byte_dat = r;
      2'd2:    byte_dat = w ? wd : {d, 1'b1};
      default: byte_dat = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] byte_cmd(input logic [1:0] i, input logic w);
    case (i)
      2'd0:    byte_cmd = 8'h91;
      2'd1:    byte_cmd = 8'h11;
      2'd2:    byte_cmd = w ? 8'h51 : 8'h91;
      default: byte_cmd = 8'h69;
    endcase
  endfunction

  // Decide the next APB access during the single idle cycle after the previous one.
  always_comb begin
    launch   = 1'b0;
    tgt_st   = state_q;
    tgt_idx  = idx_q;
    tgt_init = init_q;
    if (ap_q == AP_IDLE) begin
      case (state_q)
        S_INIT, S_SET_DR, S_SET_CMD, S_POLL, S_STOP_ON_NACK, S_RD_DR: launch = 1'b1;
        S_CHECK: begin
          if (!sr_al_q) begin
            if (sr_tip_q) begin
              launch = 1'b1;
              if (poll_q >= PW'(POLL_MAX)) begin
                tgt_st   = S_INIT;
                tgt_init = 2'd0;
              end else begin
                tgt_st = S_POLL;
              end
            end else if (!stop_q) begin
              if (cur_wr && sr_rxack_q) begin
                launch = 1'b1;
                tgt_st = S_STOP_ON_NACK;
              end else if (idx_q == last_idx) begin
                launch = !wr_q;
                tgt_st = wr_q ? S_CHECK : S_RD_DR;
              end else begin
                launch  = 1'b1;
                tgt_idx = idx_q + 2'd1;
                tgt_st  = (tgt_idx == 2'd3) ? S_SET_CMD : S_SET_DR;
              end
            end
          end
        end
        default: ;
      endcase
    end

    x_write = 1'b1;
    x_addr  = A_CTR;
    x_data  = 8'h00;
    case (tgt_st)
      S_INIT: begin
        case (tgt_init)
          2'd0:    begin x_addr = A_CTR;    x_data = 8'h00;              end
          2'd1:    begin x_addr = A_PRERLO; x_data = cfg_prescale[7:0];  end
          2'd2:    begin x_addr = A_PRERHI; x_data = cfg_prescale[15:8]; end
          default: begin x_addr = A_CTR;    x_data = 8'h80;              end
        endcase
      end
      S_SET_DR:       begin x_addr = A_DR;    x_data = byte_dat(tgt_idx, wr_q, dev_q, reg_q, wdata_q); end
      S_SET_CMD:      begin x_addr = A_CMDSR; x_data = byte_cmd(tgt_idx, wr_q); end
      S_STOP_ON_NACK: begin x_addr = A_CMDSR; x_data = 8'h41; end
      S_POLL:         begin x_addr = A_CMDSR; x_write = 1'b0; end
      S_RD_DR:        begin x_addr = A_DR;    x_write = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_INIT;   ap_q <= AP_IDLE;
      idx_q <= 2'd0;       init_q <= 2'd1;     poll_q <= '0;
      wr_q <= 1'b0;        stop_q <= 1'b0;     pend_q <= 1'b0;
      dev_q <= 7'd0;       reg_q <= 8'd0;      wdata_q <= 8'd0;
      sr_al_q <= 1'b0;     sr_tip_q <= 1'b0;   sr_rxack_q <= 1'b0;
      ready_q <= 1'b0;     valid_q <= 1'b0;    rdata_q <= 8'd0;  err_q <= 2'd0;
      psel_q <= 1'b0;      penable_q <= 1'b0;  pwrite_q <= 1'b0;
      paddr_q <= 8'd0;     pwdata_q <= 32'd0;
    end else begin
      valid_q <= 1'b0;
      case (ap_q)
        AP_SETUP: begin
          penable_q <= 1'b1;
          ap_q      <= AP_ACCESS;
        end
        AP_ACCESS: begin
          if (m_pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ap_q      <= AP_IDLE;
            case (state_q)
              S_INIT: begin
                if (init_q == 2'd3) begin
                  if (pend_q) begin
                    pend_q  <= 1'b0;
                    err_q   <= 2'd3;
                    rdata_q <= 8'd0;
                    valid_q <= 1'b1;
                    state_q <= S_RESP;
                  end else begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                  end
                end else begin
                  init_q <= init_q + 2'd1;
                end
              end
              S_SET_DR:       state_q <= S_SET_CMD;
              S_SET_CMD:      begin state_q <= S_POLL; poll_q <= '0; end
              S_STOP_ON_NACK: begin state_q <= S_POLL; poll_q <= '0; stop_q <= 1'b1; end
              S_POLL: begin
                sr_rxack_q <= m_prdata[7];
                sr_al_q    <= m_prdata[5];
                sr_tip_q   <= m_prdata[1];
                poll_q     <= poll_q + 1'b1;
                state_q    <= S_CHECK;
              end
              S_RD_DR: begin
                rdata_q <= m_prdata[7:0];
                err_q   <= 2'd0;
                valid_q <= 1'b1;
                state_q <= S_RESP;
              end
              default: ;
            endcase
          end
        end
        default: begin
          if (launch) begin
            state_q   <= tgt_st;
            idx_q     <= tgt_idx;
            init_q    <= tgt_init;
            ap_q      <= AP_SETUP;
            psel_q    <= 1'b1;
            pwrite_q  <= x_write;
            paddr_q   <= x_addr;
            pwdata_q  <= {24'd0, x_data};
            if (state_q == S_CHECK && tgt_st == S_INIT) pend_q <= 1'b1;
          end else begin
            case (state_q)
              S_IDLE: begin
                if (req_valid && ready_q) begin
                  wr_q    <= req_write;
                  dev_q   <= req_dev;
                  reg_q   <= req_reg;
                  wdata_q <= req_wdata;
                  idx_q   <= 2'd0;
                  stop_q  <= 1'b0;
                  ready_q <= 1'b0;
                  state_q <= S_SET_DR;
                end
              end
              S_CHECK: begin
                err_q   <= sr_al_q ? 2'd2 : (stop_q ? 2'd1 : 2'd0);
                rdata_q <= 8'd0;
                valid_q <= 1'b1;
                state_q <= S_RESP;
              end
              S_RESP: begin
                ready_q <= 1'b1;
                state_q <= S_IDLE;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign m_psel    = psel_q;
  assign m_penable = penable_q;
  assign m_pwrite  = pwrite_q;
  assign m_paddr   = paddr_q;
  assign m_pwdata  = pwdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed bench for i2c_xfer_seq: scripted APB slave, transfer log vs expected queue.
module tb_i2c_xfer_seq;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [15:0] cfg_prescale = 16'h0063;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [6:0]  req_dev = 7'd0;
  logic [7:0]  req_reg = 8'd0, req_wdata = 8'd0;
  logic        req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic [7:0]  m_paddr;
  logic        m_psel, m_penable, m_pwrite, m_pready;
  logic [31:0] m_pwdata, m_prdata;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  i2c_xfer_seq #(.POLL_MAX(4)) dut (
    .clk(clk), .nreset(nreset), .cfg_prescale(cfg_prescale),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  logic [7:0]  sr_val = 8'h00, dr_val = 8'h00;
  logic        stall_en = 1'b0;
  int          acc_cnt = 0, last_stall = 0;
  logic [16:0] log_q[$];
  logic [16:0] exp_q[$];
  logic        s_w, prev_psel = 1'b0;
  logic [7:0]  s_a;
  logic [31:0] s_d;
  logic [7:0]  rd;
  logic [1:0]  er;

  // APB slave: status/data registers from the script, optional 3-cycle stall on PRERHI.
  assign m_pready = !(stall_en && m_paddr == 8'h04 && acc_cnt < 3);
  assign m_prdata = (m_paddr == 8'h10) ? {24'd0, sr_val} :
                    (m_paddr == 8'h0C) ? {24'd0, dr_val} : 32'd0;

  always @(posedge clk) begin
    if (nreset) begin
      if (m_psel && !m_penable) begin
        s_w <= m_pwrite; s_a <= m_paddr; s_d <= m_pwdata;
        total++;
        assert (prev_psel === 1'b0) else begin
          bad++; $error("FAIL apb_gap: psel prev=%b exp=0", prev_psel);
        end
      end
      if (m_psel && m_penable) begin
        total++;
        assert ({m_pwrite, m_paddr, m_pwdata} === {s_w, s_a, s_d}) else begin
          bad++; $error("FAIL apb_stable: got=%h exp=%h", {m_pwrite, m_paddr, m_pwdata}, {s_w, s_a, s_d});
        end
        if (m_pready) begin
          log_q.push_back({m_pwrite, m_paddr, m_pwrite ? m_pwdata[7:0] : m_prdata[7:0]});
          if (m_paddr == 8'h04) last_stall <= acc_cnt;
          acc_cnt <= 0;
        end else begin
          acc_cnt <= acc_cnt + 1;
        end
      end
    end
    prev_psel <= m_psel;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++; $error("FAIL %s: got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic ew(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic erd(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, a, d});
  endtask

  task automatic chk_log(input string tag);
    while (exp_q.size() > 0) begin
      if (log_q.size() == 0) begin
        chk({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end else begin
        chk(tag, 32'(log_q.pop_front()), 32'(exp_q.pop_front()));
      end
    end
    chk({tag, "_extra"}, 32'(log_q.size()), 32'd0);
    log_q.delete();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 3000 && !req_ready; i++) @(negedge clk);
    chk("ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input logic w, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, output logic [7:0] rdo, output logic [1:0] ero);
    wait_ready();
    req_valid = 1'b1; req_write = w; req_dev = dev; req_reg = rg; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_dev = ~dev; req_reg = ~rg; req_wdata = ~wd;
    chk("ready_drop", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3000 && !rsp_valid; i++) @(negedge clk);
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    rdo = rsp_rdata;
    ero = rsp_err;
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_psel", 32'(m_psel), 32'd0);
    chk("rst_penable", 32'(m_penable), 32'd0);
    chk("rst_paddr", 32'(m_paddr), 32'd0);
    chk("rst_pwdata", m_pwdata, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    nreset = 1'b1;
    @(negedge clk);
    chk("ready_in_init", 32'(req_ready), 32'd0);
    wait_ready();
    ew(8'h00, 8'h63); ew(8'h04, 8'h00); ew(8'h08, 8'h80);
    chk_log("init");

    // register write, every byte ACKed
    sr_val = 8'h00;
    do_req(1'b1, 7'h50, 8'h12, 8'hA5, rd, er);
    ew(8'h0C, 8'hA0); ew(8'h10, 8'h91); erd(8'h10, 8'h00);
    ew(8'h0C, 8'h12); ew(8'h10, 8'h11); erd(8'h10, 8'h00);
    ew(8'h0C, 8'hA5); ew(8'h10, 8'h51); erd(8'h10, 8'h00);
    chk_log("wr_seq");
    chk("wr_err", 32'(er), 32'd0);
    chk("wr_rdata", 32'(rd), 32'd0);

    // register read with repeated start
    dr_val = 8'h5C;
    do_req(1'b0, 7'h50, 8'h03, 8'h00, rd, er);
    ew(8'h0C, 8'hA0); ew(8'h10, 8'h91); erd(8'h10, 8'h00);
    ew(8'h0C, 8'h03); ew(8'h10, 8'h11); erd(8'h10, 8'h00);
    ew(8'h0C, 8'hA1); ew(8'h10, 8'h91); erd(8'h10, 8'h00);
    ew(8'h10, 8'h69); erd(8'h10, 8'h00); erd(8'h0C, 8'h5C);
    chk_log("rd_seq");
    chk("rd_err", 32'(er), 32'd0);
    chk("rd_rdata", 32'(rd), 32'h5C);

    // address NACKed: stop issued, no register byte
    sr_val = 8'h80;
    do_req(1'b1, 7'h50, 8'h12, 8'hA5, rd, er);
    ew(8'h0C, 8'hA0); ew(8'h10, 8'h91); erd(8'h10, 8'h80);
    ew(8'h10, 8'h41); erd(8'h10, 8'h80);
    chk_log("nack_seq");
    chk("nack_err", 32'(er), 32'd1);
    chk("nack_rdata", 32'(rd), 32'd0);

    // arbitration lost: abort with no further writes
    sr_val = 8'h20;
    do_req(1'b0, 7'h50, 8'h03, 8'h00, rd, er);
    ew(8'h0C, 8'hA0); ew(8'h10, 8'h91); erd(8'h10, 8'h20);
    chk_log("al_seq");
    chk("al_err", 32'(er), 32'd2);
    chk("al_rdata", 32'(rd), 32'd0);

    // TIP stuck: 4 polls, core disabled, init replayed with a stalled PRERHI write
    sr_val = 8'h02;
    stall_en = 1'b1;
    do_req(1'b1, 7'h50, 8'h12, 8'hA5, rd, er);
    ew(8'h0C, 8'hA0); ew(8'h10, 8'h91);
    erd(8'h10, 8'h02); erd(8'h10, 8'h02); erd(8'h10, 8'h02); erd(8'h10, 8'h02);
    ew(8'h08, 8'h00); ew(8'h00, 8'h63); ew(8'h04, 8'h00); ew(8'h08, 8'h80);
    chk_log("to_seq");
    chk("to_err", 32'(er), 32'd3);
    chk("to_rdata", 32'(rd), 32'd0);
    chk("to_stall", 32'(last_stall), 32'd3);
    stall_en = 1'b0;

    // recovery after timeout
    sr_val = 8'h00;
    do_req(1'b1, 7'h2A, 8'h7F, 8'h3C, rd, er);
    ew(8'h0C, 8'h54); ew(8'h10, 8'h91); erd(8'h10, 8'h00);
    ew(8'h0C, 8'h7F); ew(8'h10, 8'h11); erd(8'h10, 8'h00);
    ew(8'h0C, 8'h3C); ew(8'h10, 8'h51); erd(8'h10, 8'h00);
    chk_log("rec_seq");
    chk("rec_err", 32'(er), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_xfer_seq.md
I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 SHALL have parameters: REG_PRERLO default 0, REG_PRERHI default 1, REG_CTR default 2, REG_DR default 3, REG_CMDSR default 4 (word indices; paddr = index<<2); POLL_MAX default 4095 (status polls before timeout).
REQ-002 SHALL have ports:
  clk  in  1  clock
  nreset  in  1  reset, asynchronous, active-low
  cfg_prescale  in  16  I2C prescale value, sampled during init
  req_valid  in  1  transfer request
  req_ready  out  1  sequencer idle, request accepted when both high
  req_write  in  1  1=register write, 0=register read
  req_dev  in  7  I2C device address
  req_reg  in  8  device register index
  req_wdata  in  8  write data
  rsp_valid  out  1  one-cycle completion pulse
  rsp_rdata  out  8  read data (valid with rsp_valid, read requests)
  rsp_err  out  2  0 ok, 1 NACK, 2 arbitration lost, 3 timeout
  m_paddr  out  8  APB master address
  m_psel  out  1  APB select
  m_penable  out  1  APB enable
  m_pwrite  out  1  APB direction
  m_pwdata  out  32  APB write data, bits 31:8 zero
  m_prdata  in  32  APB read data
  m_pready  in  1  APB ready

Function
REQ-003 APB transfer SHALL be: SETUP cycle (psel=1, penable=0), ACCESS cycles (psel=1, penable=1) until pready=1, then exactly one idle cycle (psel=0) before the next transfer; read data sampled on the ACCESS cycle with pready=1.
REQ-004 Address/data/write SHALL be held stable from SETUP through completion of ACCESS.
REQ-005 After reset SHALL run init: write PRERLO=cfg_prescale[7:0], PRERHI=cfg_prescale[15:8], CTR=0x80; req_ready=0 until init done.
REQ-006 Byte op = write DR with data, write CMDSR with command, then read CMDSR repeatedly until bit1 (TIP)=0.
REQ-007 Every command write SHALL include IACK (bit0=1); command bits: STA 0x80, STO 0x40, RD 0x20, WR 0x10, ACK 0x08 (NACK on read).
REQ-008 Write request sequence: {dev<<1|0, 0x91}, {reg, 0x11}, {wdata, 0x51}.
REQ-009 Read request sequence: {dev<<1|0, 0x91}, {reg, 0x11}, {dev<<1|1, 0x91}, {no DR write, 0x69}, then read DR; rsp_rdata = DR[7:0].
REQ-010 After each poll completes: SR bit5 (AL)=1 -> abort, rsp_err=2, no further APB writes; else after a WR byte SR bit7 (RXACK)=1 -> write CMDSR=0x41, poll TIP-free, rsp_err=1.
REQ-011 Poll counter SHALL reset per byte op; POLL_MAX polls with TIP=1 -> rsp_err=3, write CTR=0x00 then re-run init before req_ready.
REQ-012 rsp_valid SHALL pulse one cycle at sequence end; req_ready SHALL rise the following cycle; request fields captured at acceptance.
REQ-013 States: INIT, IDLE, SET_DR, SET_CMD, POLL, CHECK, STOP_ON_NACK, RD_DR, RESP; inputs changing mid-sequence SHALL not affect it.
REQ-014 rsp_rdata SHALL be 0 on non-read or errored responses.

Reset
REQ-015 nreset low SHALL asynchronously force: state INIT (restart), m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, poll counter 0; reset mid-transfer aborts with no response.

Verification
REQ-016 Reset release, cfg_prescale=0x0063, pready=1 -> APB writes 0x00<-0x63, 0x04<-0x00, 0x08<-0x80, then req_ready=1.
REQ-017 Write dev=0x50 reg=0x12 data=0xA5, model ACKs -> DR/CMD pairs 0xA0/0x91, 0x12/0x11, 0xA5/0x51; rsp_err=0.
REQ-018 Read dev=0x50 reg=0x03, DR returns 0x5C -> third byte 0xA1/0x91, cmd 0x69, rsp_rdata=0x5C, rsp_err=0.
REQ-019 RXACK=1 after address byte -> CMDSR write 0x41, rsp_err=1, no reg byte issued.
REQ-020 TIP stuck high, POLL_MAX=4 -> after 4 polls rsp_err=3, CTR<-0x00 then init replayed; also pready held low 3 cycles on one access -> transfer extended, data unchanged.
